rr_ring_arbiter: RTL and testbench

Round-robin arbiter that shares one resource (the ring-counter datapath or any single-owner unit) among N requesters. A one-hot token pointer rotates like a ring counter and sets the search start each time the resource is released. Grants are registered, one-hot and never overlap. The arbiter sits between requesting masters and the shared unit and drives its select/enable.

---
 rtl/rr_arb_pkg.sv | 16 +
 rtl/token_ring.sv | 21 ++
 rtl/rr_ring_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_ring_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and defaults for rr_ring_arbiter
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 8;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/token_ring.sv
// rtl/token_ring.sv - one-hot rotating token pointer, async active-low reset to bit0
module token_ring #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rot_en,
    input  logic [N-1:0] seed,
    output logic [N-1:0] ptr
);

    // On rotate the token lands just past the seed (the departing owner).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= {{(N-1){1'b0}}, 1'b1};
        end else if (rot_en) begin
            ptr <= {seed[N-2:0], seed[N-1]};
        end
    end

endmodule

// File: rtl/rr_ring_arbiter.sv
// rtl/rr_ring_arbiter.sv - round-robin arbiter with ring token pointer; optional ARB_TIMEOUT_EN
module rr_ring_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [N-1:0]           req,
    input  logic                   release_grant,
    output logic [N-1:0]           grant,
    output logic [id_width(N)-1:0] grant_id,
    output logic                   grant_valid,
    output logic [N-1:0]           ptr,
    output logic                   timeout
);

    localparam int IDW = id_width(N);

    if (N < 2 || N > 16 || MAX_HOLD < 1) begin : g_param_check
        $error("rr_ring_arbiter: N must be 2..16 and MAX_HOLD >= 1");
    end

    arb_state_t     state;
    logic [N-1:0]   start_oh;
    logic [IDW-1:0] start_idx;
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [N-1:0]   win_oh;
    logic           owner_req;
    logic           force_rel;
    logic           rel_cond;

    assign owner_req = |(grant & req);
    assign rel_cond  = (state == GRANT) && (release_grant || !owner_req || force_rel);

    // In GRANT the search already starts past the owner, so a handoff needs no bubble.
    always_comb begin
        start_oh  = (state == GRANT) ? {grant[N-2:0], grant[N-1]} : ptr;
        start_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (start_oh[i]) start_idx = i[IDW-1:0];
        end
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(start_idx) + k;
            if (idx >= N) idx = idx - N;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx[IDW-1:0];
            end
        end
        win_oh = '0;
        if (win_found) win_oh[win_idx] = 1'b1;
    end

    token_ring #(.N(N)) u_token_ring (
        .clk    (clk),
        .reset  (reset),
        .rot_en (rel_cond),
        .seed   (grant),
        .ptr    (ptr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && win_found) begin
                        state       <= GRANT;
                        grant       <= win_oh;
                        grant_id    <= win_idx;
                        grant_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (rel_cond) begin
                        if (en && win_found) begin
                            grant       <= win_oh;
                            grant_id    <= win_idx;
                        end else begin
                            state       <= IDLE;
                            grant       <= '0;
                            grant_id    <= '0;
                            grant_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int HCW = $clog2(MAX_HOLD + 1);

    logic [HCW-1:0] hold_cnt;

    assign force_rel = (state == GRANT) && (hold_cnt == HCW'(MAX_HOLD - 1))
                       && !release_grant && owner_req;

    // Cleared whenever the grant changes hands or goes idle, so every new owner starts at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= force_rel;
            if (state == GRANT && !rel_cond) hold_cnt <= hold_cnt + 1'b1;
            else                             hold_cnt <= '0;
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// tb/tb_rr_ring_arbiter.sv - directed self-checking bench for rr_ring_arbiter
module tb_rr_ring_arbiter;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] req;
    logic       release_grant;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic [3:0] ptr;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    rr_ring_arbiter #(.N(4), .MAX_HOLD(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .req           (req),
        .release_grant (release_grant),
        .grant         (grant),
        .grant_id      (grant_id),
        .grant_valid   (grant_valid),
        .ptr           (ptr),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] seq_exp [4];
    int bad;
    int pulses;

    initial begin
        seq_exp[0] = 4'b0010; seq_exp[1] = 4'b0100; seq_exp[2] = 4'b1000; seq_exp[3] = 4'b0001;
        reset = 1'b1; en = 1'b0; req = '0; release_grant = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant", grant, 4'b0000);
        check("rst_ptr", ptr, 4'b0001);
        check("rst_valid", grant_valid, 1'b0);
        check("rst_id", grant_id, 2'd0);
        check("rst_timeout", timeout, 1'b0);
        reset = 1'b1;

        // single requester, grant then drop with release
        req = 4'b0001; en = 1'b1;
        tick();
        check("single_grant", grant, 4'b0001);
        check("single_id", grant_id, 2'd0);
        check("single_valid", grant_valid, 1'b1);
        req = 4'b0000; release_grant = 1'b1;
        tick();
        release_grant = 1'b0;
        check("single_rel_grant", grant, 4'b0000);
        check("single_rel_ptr", ptr, 4'b0010);
        check("single_rel_valid", grant_valid, 1'b0);

        // release in IDLE is ignored
        release_grant = 1'b1;
        tick();
        release_grant = 1'b0;
        check("idle_rel_ptr", ptr, 4'b0010);
        check("idle_rel_grant", grant, 4'b0000);

        // reset back to bit0 then full rotation with release every 3rd cycle
        reset = 1'b0; #1 reset = 1'b1;
        req = 4'b1111;
        tick();
        check("rot_first", grant, 4'b0001);
        for (int s = 0; s < 4; s++) begin
            tick();
            tick();
            check("rot_hold", grant, (s == 0) ? 4'b0001 : seq_exp[s-1]);
            release_grant = 1'b1;
            tick();
            release_grant = 1'b0;
            check("rot_next", grant, seq_exp[s]);
            check("rot_id", grant_id, (s == 3) ? 2'd0 : 2'(s + 1));
        end

        // owner drops -> idle; en=0 blocks new grants
        req = 4'b0000;
        tick();
        check("drop_grant", grant, 4'b0000);
        check("drop_ptr", ptr, 4'b0010);
        en = 1'b0; req = 4'b0010;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (grant !== 4'b0000) bad++;
        end
        check("en0_no_grant", bad, 0);
        en = 1'b1;
        tick();
        check("en1_grant", grant, 4'b0010);
        check("en1_id", grant_id, 2'd1);
        en = 1'b0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (grant !== 4'b0010) bad++;
        end
        check("en0_held", bad, 0);

        // owner 1 drops while 2 requests -> direct handoff, then wrap from 3 to 0
        en = 1'b1; req = 4'b0100;
        tick();
        check("hand_grant", grant, 4'b0100);
        check("hand_ptr", ptr, 4'b0100);
        req = 4'b0101; release_grant = 1'b1;
        tick();
        release_grant = 1'b0;
        check("wrap_ptr", ptr, 4'b1000);
        check("wrap_grant", grant, 4'b0001);
        check("wrap_id", grant_id, 2'd0);

        // long hold by owner 0
        req = 4'b0001;
        bad = 0; pulses = 0;
        for (int c = 0; c < 52; c++) begin
            tick();
            if (grant !== 4'b0001) bad++;
            if (timeout === 1'b1) pulses++;
        end
        check("hold_grant", bad, 0);
`ifdef ARB_TIMEOUT_EN
        check("hold_timeouts", pulses, 6);
        check("hold_ptr", ptr, 4'b0010);
`else
        check("hold_timeouts", pulses, 0);
        check("hold_ptr", ptr, 4'b1000);
`endif

        // async reset mid-grant
        req = 4'b0100;
        tick();
        check("pre_rst_grant", grant, 4'b0100);
        #2 reset = 1'b0;
        #1;
        check("async_rst_grant", grant, 4'b0000);
        check("async_rst_ptr", ptr, 4'b0001);
        check("async_rst_valid", grant_valid, 1'b0);
        @(negedge clk);
        reset = 1'b1; req = 4'b0000;
        tick();
        check("post_rst_grant", grant, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
